// File: rtl/store_buffer.sv
// In-order store FIFO draining one registered memory write per cycle, with
// combinational store-to-load forwarding over pending entries and the output register.
module store_buffer #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int DMEMADDRBITS   = 13,
    parameter int DMEMWORDBITS   = 2,
    parameter int DEPTH          = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stValid,
    input  logic [DATA_BIT_WIDTH-1:0]    stAddr,
    input  logic [DATA_BIT_WIDTH-1:0]    stData,
    output logic                         stReady,
    input  logic                         drainEn,
    output logic                         isWrRegMem,
    output logic [DATA_BIT_WIDTH-1:0]    memAddr,
    output logic [DATA_BIT_WIDTH-1:0]    memData,
    input  logic [DATA_BIT_WIDTH-1:0]    ldAddr,
    output logic                         ldHit,
    output logic [DATA_BIT_WIDTH-1:0]    ldData,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_BIT_WIDTH-1:0] addr;
        logic [DATA_BIT_WIDTH-1:0] data;
    } entry_t;

    entry_t            ent [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic              wr_vld;
    logic [DATA_BIT_WIDTH-1:0] wr_addr;
    logic [DATA_BIT_WIDTH-1:0] wr_data;

    logic enq;
    logic deq;

    assign stReady = !reset && (cnt < DEPTH_C);
    assign enq     = stValid && stReady;
    assign deq     = (cnt != '0) && drainEn;

    assign count      = cnt;
    assign isWrRegMem = wr_vld;
    assign memAddr    = wr_addr;
    assign memData    = wr_data;
    assign empty      = (cnt == '0) && !wr_vld;

    // Entry storage carries no reset; occupancy is tracked solely by cnt.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent[tail] <= '{addr: stAddr, data: stData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head    <= head + PW'(1);
                wr_vld  <= 1'b1;
                wr_addr <= ent[head].addr;
                wr_data <= ent[head].data;
            end else begin
                wr_vld  <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Forwarding scans oldest to youngest so the last match wins; the
    // output register is older than anything still in the FIFO.
    logic [DMEMADDRBITS-DMEMWORDBITS-1:0] ld_word;
    logic [PW-1:0]                        scan_idx;
    logic                                 hit;
    logic [DATA_BIT_WIDTH-1:0]            fwd_data;

    assign ld_word = ldAddr[DMEMADDRBITS-1:DMEMWORDBITS];

    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        if (wr_vld && (wr_addr[DMEMADDRBITS-1:DMEMWORDBITS] == ld_word)) begin
            hit      = 1'b1;
            fwd_data = wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if ((CW'(i) < cnt) &&
                (ent[scan_idx].addr[DMEMADDRBITS-1:DMEMWORDBITS] == ld_word)) begin
                hit      = 1'b1;
                fwd_data = ent[scan_idx].data;
            end
        end
    end

    assign ldHit  = hit;
    assign ldData = fwd_data;

    logic unused_ld_bits;
    assign unused_ld_bits = ^{ldAddr[DATA_BIT_WIDTH-1:DMEMADDRBITS], ldAddr[DMEMWORDBITS-1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stValid;
    logic [31:0] stAddr;
    logic [31:0] stData;
    logic        stReady;
    logic        drainEn;
    logic        isWrRegMem;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic [31:0] ldAddr;
    logic        ldHit;
    logic [31:0] ldData;
    logic [2:0]  count;
    logic        empty;

    int errors = 0;
    int checks = 0;

    store_buffer #(
        .DATA_BIT_WIDTH(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stValid(stValid), .stAddr(stAddr), .stData(stData),
        .stReady(stReady), .drainEn(drainEn), .isWrRegMem(isWrRegMem), .memAddr(memAddr),
        .memData(memData), .ldAddr(ldAddr), .ldHit(ldHit), .ldData(ldData),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        stValid = 1'b1; stAddr = a; stData = d;
        step();
        stValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stValid = 1'b1; stAddr = 32'h99; stData = 32'h55;
        drainEn = 1'b1; ldAddr = 32'h0;
        #1;
        checks++; if (stReady !== 1'b0) begin errors++; $display("FAIL reset_stready_during: got %b want 0", stReady); end
        step();
        step();
        checks++; if (stReady !== 1'b0) begin errors++; $display("FAIL reset_stready_held: got %b want 0", stReady); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (isWrRegMem !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", isWrRegMem); end
        checks++; if (memAddr !== 32'h0 || memData !== 32'h0) begin errors++; $display("FAIL reset_mem: got %h/%h want 0/0", memAddr, memData); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        reset = 1'b0; stValid = 1'b0;
        #1;
        checks++; if (stReady !== 1'b1) begin errors++; $display("FAIL reset_stready_after: got %b want 1", stReady); end
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_no_enq: got count %0d want 0", count); end
    endtask

    task automatic test_single();
        drainEn = 1'b1;
        push(32'h10, 32'hDEADBEEF);
        checks++; if (isWrRegMem !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL single_edge0: got wr=%b count=%0d want wr=0 count=1", isWrRegMem, count); end
        step();
        checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'h10 || memData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_edge1: got wr=%b %h/%h want 1 00000010/deadbeef", isWrRegMem, memAddr, memData); end
        checks++; if (empty !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_edge1_occ: got empty=%b count=%0d want 0/0", empty, count); end
        step();
        checks++; if (isWrRegMem !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL single_edge2: got wr=%b empty=%b want 0/1", isWrRegMem, empty); end
        checks++; if (memAddr !== 32'h10) begin errors++; $display("FAIL single_hold: got %h want 00000010", memAddr); end
    endtask

    task automatic test_fill();
        drainEn = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(4 * i), 32'h100 + 32'(i));
        checks++; if (count !== 3'd4 || stReady !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d rdy=%b want 4/0", count, stReady); end
        push(32'h10, 32'hBAD);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_drop: got count=%0d want 4", count); end
        // Full with drain in the same cycle still refuses the store.
        stValid = 1'b1; stAddr = 32'h14; stData = 32'hBAD2; drainEn = 1'b1;
        #1;
        checks++; if (stReady !== 1'b0) begin errors++; $display("FAIL fill_full_drain_rdy: got %b want 0", stReady); end
        for (int k = 0; k < 4; k++) begin
            step();
            stValid = 1'b0;
            checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'(4 * k) || memData !== 32'h100 + 32'(k)) begin
                errors++; $display("FAIL fill_drain%0d: got wr=%b %h/%h want 1 %h/%h", k, isWrRegMem, memAddr, memData, 32'(4 * k), 32'h100 + 32'(k)); end
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_count_end: got %0d want 0", count); end
        step();
        checks++; if (isWrRegMem !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got wr=%b empty=%b want 0/1", isWrRegMem, empty); end
    endtask

    task automatic test_forwarding();
        drainEn = 1'b0;
        push(32'h20, 32'h1111);
        push(32'h20, 32'h2222);
        ldAddr = 32'h20; #1;
        checks++; if (ldHit !== 1'b1 || ldData !== 32'h2222) begin errors++; $display("FAIL fwd_20: got %b/%h want 1/2222", ldHit, ldData); end
        ldAddr = 32'h22; #1;
        checks++; if (ldHit !== 1'b1 || ldData !== 32'h2222) begin errors++; $display("FAIL fwd_22: got %b/%h want 1/2222", ldHit, ldData); end
        ldAddr = 32'h24; #1;
        checks++; if (ldHit !== 1'b0 || ldData !== 32'h0) begin errors++; $display("FAIL fwd_24: got %b/%h want 0/0", ldHit, ldData); end
        ldAddr = 32'h2020; #1;
        checks++; if (ldHit !== 1'b1 || ldData !== 32'h2222) begin errors++; $display("FAIL fwd_alias: got %b/%h want 1/2222", ldHit, ldData); end
        ldAddr = 32'h20;
        drainEn = 1'b1;
        step();
        drainEn = 1'b0;
        checks++; if (ldHit !== 1'b1 || ldData !== 32'h2222) begin errors++; $display("FAIL fwd_young_over_reg: got %b/%h want 1/2222", ldHit, ldData); end
        push(32'h40, 32'h3333);
        drainEn = 1'b1;
        step();
        drainEn = 1'b0;
        checks++; if (ldHit !== 1'b1 || ldData !== 32'h2222 || memData !== 32'h2222) begin
            errors++; $display("FAIL fwd_outreg: got %b/%h mem %h want 1/2222 mem 2222", ldHit, ldData, memData); end
        drainEn = 1'b1;
        step(); step();
        drainEn = 1'b0;
        checks++; if (ldHit !== 1'b0 || ldData !== 32'h0 || empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got %b/%h empty %b want 0/0 1", ldHit, ldData, empty); end
    endtask

    task automatic test_simultaneous();
        drainEn = 1'b0;
        push(32'h30, 32'hA);
        push(32'h34, 32'hB);
        stValid = 1'b1; stAddr = 32'h38; stData = 32'hC; drainEn = 1'b1;
        step();
        stValid = 1'b0;
        checks++; if (count !== 3'd2 || isWrRegMem !== 1'b1 || memAddr !== 32'h30 || memData !== 32'hA) begin
            errors++; $display("FAIL simul_a: got count=%0d wr=%b %h/%h want 2 1 30/a", count, isWrRegMem, memAddr, memData); end
        step();
        checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'h34 || memData !== 32'hB) begin errors++; $display("FAIL simul_b: got %b %h/%h want 1 34/b", isWrRegMem, memAddr, memData); end
        step();
        checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'h38 || memData !== 32'hC || count !== 3'd0) begin
            errors++; $display("FAIL simul_c: got %b %h/%h count %0d want 1 38/c 0", isWrRegMem, memAddr, memData, count); end
        step();
        checks++; if (isWrRegMem !== 1'b0) begin errors++; $display("FAIL simul_end: got %b want 0", isWrRegMem); end
    endtask

    task automatic test_back_to_back();
        drainEn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stValid = 1'b1; stAddr = 32'h100 + 32'(4 * i); stData = 32'hC0 + 32'(i);
            step();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count%0d: got %0d want 1", i, count); end
            if (i > 0) begin
                checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'h100 + 32'(4 * (i - 1)) || memData !== 32'hC0 + 32'(i - 1)) begin
                    errors++; $display("FAIL stream_drain%0d: got %b %h/%h want 1 %h/%h", i, isWrRegMem, memAddr, memData, 32'h100 + 32'(4 * (i - 1)), 32'hC0 + 32'(i - 1)); end
            end
        end
        stValid = 1'b0;
        step();
        checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'h124 || memData !== 32'hC9 || count !== 3'd0) begin
            errors++; $display("FAIL stream_last: got %b %h/%h count %0d want 1 124/c9 0", isWrRegMem, memAddr, memData, count); end
        step();
    endtask

    task automatic test_reset_mid_drain();
        drainEn = 1'b0;
        push(32'h50, 32'h5);
        push(32'h54, 32'h6);
        push(32'h58, 32'h7);
        drainEn = 1'b1;
        step();
        ldAddr = 32'h50; #1;
        checks++; if (isWrRegMem !== 1'b1 || memAddr !== 32'h50 || ldHit !== 1'b1 || ldData !== 32'h5) begin
            errors++; $display("FAIL mid_first: got %b %h hit %b %h want 1 50 1 5", isWrRegMem, memAddr, ldHit, ldData); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (isWrRegMem !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_after_reset: got wr=%b count=%0d want 0/0", isWrRegMem, count); end
        for (int k = 0; k < 3; k++) begin
            ldAddr = 32'h50 + 32'(4 * k); #1;
            checks++; if (ldHit !== 1'b0 || ldData !== 32'h0) begin errors++; $display("FAIL mid_fwd%0d: got %b/%h want 0/0", k, ldHit, ldData); end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (isWrRegMem !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_quiet%0d: got wr=%b empty=%b want 0/1", k, isWrRegMem, empty); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forwarding();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
